// File: rtl/midi_event_sequencer_if.sv
// midi_event_sequencer_if: event stream from the sequencer FIFO head to the synth consumer
interface midi_event_sequencer_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [2:0] ev_type;
  logic [3:0] ev_chan;
  logic [6:0] ev_d1;
  logic [6:0] ev_d2;
  modport master (output ev_valid, ev_type, ev_chan, ev_d1, ev_d2, input ev_ready);
  modport slave  (input ev_valid, ev_type, ev_chan, ev_d1, ev_d2, output ev_ready);
endinterface

// File: rtl/midi_event_sequencer.sv
// midi_event_sequencer: resync MIDI bytes, parse with running status, filter by channel, queue events
module midi_event_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic                  CLOCK_25,
  input  logic                  iRST_N,
  input  logic                  byteready_in,
  input  logic [7:0]            midibyte_in,
  input  logic [3:0]            channel_sel,
  input  logic                  omni,
  input  logic                  ovf_clr,
  midi_event_sequencer_if.master ev,
  output logic                  rt_pulse,
  output logic [7:0]            rt_code,
  output logic [FIFO_AW:0]      fifo_level,
  output logic                  overflow
);
  typedef enum logic [1:0] {NOSTAT, SYSEX, WAIT_D1, WAIT_D2} state_t;
  localparam logic [FIFO_AW:0] FULL = (FIFO_AW+1)'(FIFO_DEPTH);
  state_t             state_q;
  logic [2:0]         sync_q;
  logic [7:0]         status_q;
  logic [6:0]         d1_q;
  logic               push_q;
  logic [20:0]        push_data_q;
  logic               rt_pulse_q;
  logic [7:0]         rt_code_q;
  logic [20:0]        mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_q, rd_q;
  logic [FIFO_AW:0]   level_q;
  logic               overflow_q;
  logic               byte_stb, one_byte, emit, chan_ok, pop, full, push_ok, drop;
  logic [6:0]         emit_d1, emit_d2;
  logic [2:0]         emit_type;
  logic [20:0]        head;
  // Byte strobe, message completion and event fields for the byte currently strobed
  always_comb begin
    byte_stb  = sync_q[1] & ~sync_q[2];
    one_byte  = status_q[6:5] == 2'b10;
    emit      = byte_stb & ~midibyte_in[7] & ((state_q == WAIT_D1 & one_byte) | state_q == WAIT_D2);
    emit_d1   = state_q == WAIT_D2 ? d1_q : midibyte_in[6:0];
    emit_d2   = state_q == WAIT_D2 ? midibyte_in[6:0] : 7'd0;
    emit_type = (status_q[6:4] == 3'd1 && emit_d2 == 7'd0) ? 3'd0 : status_q[6:4];
    chan_ok   = omni | (status_q[3:0] == channel_sel);
    full      = level_q == FULL;
    pop       = (level_q != '0) & ev.ev_ready;
    push_ok   = push_q & (~full | pop);
    drop      = push_q & full & ~pop;
    head      = level_q != '0 ? mem_q[rd_q] : '0;
  end
  // Synchroniser, parser FSM and registered push / real-time strobes
  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      sync_q      <= '0;
      state_q     <= NOSTAT;
      status_q    <= '0;
      d1_q        <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      rt_pulse_q  <= 1'b0;
      rt_code_q   <= '0;
    end else begin
      sync_q     <= {sync_q[1:0], byteready_in};
      rt_pulse_q <= 1'b0;
      push_q     <= 1'b0;
      if (byte_stb) begin
        if (midibyte_in >= 8'hF8) begin
          rt_code_q  <= midibyte_in;
          rt_pulse_q <= 1'b1;
        end else if (midibyte_in >= 8'hF0) begin
          status_q <= '0;
          state_q  <= midibyte_in == 8'hF0 ? SYSEX : NOSTAT;
        end else if (midibyte_in[7]) begin
          status_q <= midibyte_in;
          state_q  <= WAIT_D1;
        end else if (state_q == WAIT_D1) begin
          d1_q    <= midibyte_in[6:0];
          state_q <= one_byte ? WAIT_D1 : WAIT_D2;
        end else if (state_q == WAIT_D2) begin
          state_q <= WAIT_D1;
        end
        push_q      <= emit & chan_ok;
        push_data_q <= {emit_type, status_q[3:0], emit_d1, emit_d2};
      end
    end
  end
  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      wr_q       <= '0;
      rd_q       <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_q       <= push_ok ? wr_q + 1'b1 : wr_q;
      rd_q       <= pop ? rd_q + 1'b1 : rd_q;
      level_q    <= (push_ok & ~pop) ? level_q + 1'b1 : (pop & ~push_ok) ? level_q - 1'b1 : level_q;
      overflow_q <= drop ? 1'b1 : ovf_clr ? 1'b0 : overflow_q;
    end
  end
  // Event storage; contents are only visible through the valid-masked head
  always_ff @(posedge CLOCK_25) begin
    if (push_ok) mem_q[wr_q] <= push_data_q;
  end
  assign ev.ev_valid = level_q != '0;
  assign {ev.ev_type, ev.ev_chan, ev.ev_d1, ev.ev_d2} = head;
  assign rt_pulse   = rt_pulse_q;
  assign rt_code    = rt_code_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
endmodule
